// File: rtl/fp_mul_scheduler.sv
// Round-robin front end for one shared custom-float multiplier.
// S1 operand register -> combinational multiply -> S2 result register.
module fp_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MAN_A = 23,
  parameter int MAN_B = 23,
  localparam int MAN_R = MAN_A + MAN_B + 1,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*(MAN_A+9)-1:0]  req_a,
  input  logic [NUM_REQ*(MAN_B+9)-1:0]  req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [MAN_R+8:0]              res_data,
  output logic [ID_W-1:0]               res_id,
  output logic                          busy
);

  localparam int WA = MAN_A + 9;
  localparam int WB = MAN_B + 9;

  logic            s1_vld;
  logic [WA-1:0]   s1_a;
  logic [WB-1:0]   s1_b;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] last_grant;

  logic s2_adv;
  logic s1_adv;
  logic s1_free;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic            accept;
  logic [WA-1:0]   a_sel;
  logic [WB-1:0]   b_sel;

  assign s2_adv  = !res_valid | res_ready;
  assign s1_adv  = s1_vld & s2_adv;
  assign s1_free = !s1_vld | s1_adv;
  assign accept  = s1_free & gnt_found;
  assign busy    = s1_vld | res_valid;

  // Rotating-priority search starting one past the last winner.
  always_comb begin
    int cand;
    logic [ID_W-1:0] cand_idx;
    gnt_found = 1'b0;
    gnt_idx = '0;
    cand = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ)
        cand = cand - NUM_REQ;
      cand_idx = cand[ID_W-1:0];
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  // Grant is one-hot to the winner, suppressed while held in reset.
  always_comb begin
    req_ready = '0;
    if (!rst && accept)
      req_ready[gnt_idx] = 1'b1;
  end

  // Mux the winning requester's operands.
  always_comb begin
    a_sel = req_a[int'(gnt_idx)*WA +: WA];
    b_sel = req_b[int'(gnt_idx)*WB +: WB];
  end

  logic              m_sign;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic [MAN_A:0]    ma_ext;
  logic [MAN_B:0]    mb_ext;
  logic [MAN_R:0]    prod;
  logic [7:0]        m_exp;
  logic [MAN_R-1:0]  m_man;
  logic [MAN_R+8:0]  m_res;

  // Multiply S1 operands; exponent wraps mod 256, zero exponent flushes.
  always_comb begin
    m_sign = s1_a[WA-1] ^ s1_b[WB-1];
    ea = s1_a[WA-2 -: 8];
    eb = s1_b[WB-2 -: 8];
    ma_ext = {1'b1, s1_a[MAN_A-1:0]};
    mb_ext = {1'b1, s1_b[MAN_B-1:0]};
    prod = (MAN_R+1)'(ma_ext) * (MAN_R+1)'(mb_ext);
    m_exp = ea + eb + 8'd129 + {7'd0, prod[MAN_R]};
    if (prod[MAN_R])
      m_man = prod[MAN_R-1:0];
    else
      m_man = {prod[MAN_R-2:0], 1'b0};
    if (ea == 8'd0 || eb == 8'd0)
      m_res = {m_sign, 8'd0, {MAN_R{1'b0}}};
    else
      m_res = {m_sign, m_exp, m_man};
  end

  // S1 operand register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_id <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (s1_free) begin
      s1_vld <= gnt_found;
      if (gnt_found) begin
        s1_a <= a_sel;
        s1_b <= b_sel;
        s1_id <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end

  // S2 result register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= '0;
    end else if (s2_adv) begin
      res_valid <= s1_vld;
      if (s1_vld) begin
        res_data <= m_res;
        res_id <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed bench for fp_mul_scheduler with default parameters.
// Each scenario task drives stimulus and checks inline.
module tb_fp_mul_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [55:0]  res_data;
  logic [1:0]   res_id;
  logic         busy;

  int total = 0;
  int bad = 0;

  fp_mul_scheduler dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Sample handshakes, cross one rising edge, retire accepted requests.
  task automatic tick(output logic [3:0] acc);
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a,
                         input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // Present one op and advance to the cycle its result is visible.
  task automatic issue(input int i, input logic [31:0] a,
                       input logic [31:0] b, output logic [3:0] acc);
    logic [3:0] d;
    set_ops(i, a, b);
    req_valid = 4'b0001 << i;
    tick(acc);
    tick(d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 4'h0) begin
      bad++;
      $display("FAIL rst_ready got=%h exp=0", req_ready);
    end
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b/%b exp=0/0", res_valid, busy);
    end
    total++;
    if (res_data !== 56'h0 || res_id !== 2'd0) begin
      bad++;
      $display("FAIL rst_data got=%h/%0d exp=0/0", res_data, res_id);
    end
    req_valid = 4'h0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [3:0] acc;
    set_ops(0, 32'h40000000, 32'h40400000);
    req_valid = 4'b0001;
    tick(acc);
    total++;
    if (acc !== 4'b0001) begin
      bad++;
      $display("FAIL single_accept got=%b exp=0001", acc);
    end
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_lat got=%b/%b exp=0/1", res_valid, busy);
    end
    tick(acc);
    total++;
    if (res_valid !== 1'b1 || res_data !== 56'h40C00000000000 ||
        res_id !== 2'd0) begin
      bad++;
      $display("FAIL single_res got=%b %h %0d exp=1 40c00000000000 0",
               res_valid, res_data, res_id);
    end
    tick(acc);
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_drain got=%b/%b exp=0/0", res_valid, busy);
    end
  endtask

  task automatic test_sign;
    logic [3:0] acc;
    issue(1, 32'h3F800000, 32'h3F800000, acc);
    total++;
    if (acc !== 4'b0010 || res_valid !== 1'b1 ||
        res_data !== 56'h3F800000000000 || res_id !== 2'd1) begin
      bad++;
      $display("FAIL unity got=%b %b %h %0d exp=0010 1 3f800000000000 1",
               acc, res_valid, res_data, res_id);
    end
    issue(1, 32'h40000000, 32'hC0400000, acc);
    total++;
    if (res_valid !== 1'b1 || res_data !== 56'hC0C00000000000) begin
      bad++;
      $display("FAIL neg got=%b %h exp=1 c0c00000000000",
               res_valid, res_data);
    end
    issue(1, 32'h3FC00000, 32'h3FC00000, acc);
    total++;
    if (res_valid !== 1'b1 || res_data !== 56'h40100000000000) begin
      bad++;
      $display("FAIL carry got=%b %h exp=1 40100000000000",
               res_valid, res_data);
    end
  endtask

  task automatic test_zero;
    logic [3:0] acc;
    issue(2, 32'h00000000, 32'h40400000, acc);
    total++;
    if (res_valid !== 1'b1 || res_data !== 56'h0 || res_id !== 2'd2) begin
      bad++;
      $display("FAIL zero_pos got=%b %h %0d exp=1 0 2",
               res_valid, res_data, res_id);
    end
    issue(3, 32'h80000000, 32'h40400000, acc);
    total++;
    if (res_valid !== 1'b1 || res_data !== 56'h80000000000000 ||
        res_id !== 2'd3) begin
      bad++;
      $display("FAIL zero_neg got=%b %h %0d exp=1 80000000000000 3",
               res_valid, res_data, res_id);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] acc;
    logic [3:0] exp_acc;
    logic [55:0] exp_d;
    for (int i = 0; i < 4; i++)
      set_ops(i, 32'h3F800000, {1'b0, 8'(128 + i), 23'd0});
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      tick(acc);
      exp_acc = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      total++;
      if (acc !== exp_acc) begin
        bad++;
        $display("FAIL rr_grant k=%0d got=%b exp=%b", k, acc, exp_acc);
      end
      if (k >= 1 && k <= 8) begin
        exp_d = {1'b0, 8'(128 + (k - 1) % 4), 47'd0};
        total++;
        if (res_valid !== 1'b1 || res_id !== 2'((k - 1) % 4) ||
            res_data !== exp_d) begin
          bad++;
          $display("FAIL rr_res k=%0d got=%b %0d %h exp=1 %0d %h",
                   k, res_valid, res_id, res_data, (k - 1) % 4, exp_d);
        end
      end else begin
        total++;
        if (res_valid !== 1'b0) begin
          bad++;
          $display("FAIL rr_idle k=%0d got=%b exp=0", k, res_valid);
        end
      end
    end
  endtask

  task automatic test_back_pressure;
    logic [3:0] acc;
    int n;
    n = 0;
    res_ready = 1'b0;
    req_valid = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      tick(acc);
      n += $countones(acc);
      total++;
      if (acc !== ((k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : 4'b0000)) begin
        bad++;
        $display("FAIL bp_grant k=%0d got=%b", k, acc);
      end
    end
    total++;
    if (n != 2 || req_ready !== 4'h0) begin
      bad++;
      $display("FAIL bp_count got=%0d %b exp=2 0000", n, req_ready);
    end
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold got=%b %0d %b exp=1 0 1",
               res_valid, res_id, busy);
    end
    res_ready = 1'b1;
    tick(acc);
    total++;
    if (acc !== 4'b0100 || res_valid !== 1'b1 || res_id !== 2'd1 ||
        res_data !== {1'b0, 8'd129, 47'd0}) begin
      bad++;
      $display("FAIL bp_rel1 got=%b %b %0d %h exp=0100 1 1",
               acc, res_valid, res_id, res_data);
    end
    tick(acc);
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd2 ||
        res_data !== {1'b0, 8'd130, 47'd0}) begin
      bad++;
      $display("FAIL bp_rel2 got=%b %0d %h exp=1 2",
               res_valid, res_id, res_data);
    end
    tick(acc);
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_dup got=%b/%b exp=0/0", res_valid, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] acc;
    res_ready = 1'b0;
    req_valid = 4'hF;
    tick(acc);
    req_valid = 4'hF;
    tick(acc);
    req_valid = 4'hF;
    total++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_full got=%b/%b exp=1/1", res_valid, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
      bad++;
      $display("FAIL mid_rst got=%b %b %b exp=0 0 0000",
               res_valid, busy, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    tick(acc);
    total++;
    if (acc !== 4'b0001 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_first got=%b %b exp=0001 0", acc, res_valid);
    end
    req_valid = 4'h0;
    tick(acc);
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd0) begin
      bad++;
      $display("FAIL mid_res got=%b %0d exp=1 0", res_valid, res_id);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_sign;
    test_zero;
    test_round_robin;
    test_back_pressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
